// File: rtl/if_id_queue.sv
// Two-entry fetch-to-decode instruction queue with valid/ready handshakes on both sides
// and a single-cycle flush for taken branches.
module if_id_queue #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_instr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic [1:0]  count_o
);

  logic [31:0] pc_mem    [2];
  logic [31:0] instr_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        push;
  logic        pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready_o  = (count != 2'd2);
  assign out_valid_o = (count != 2'd0);
  assign count_o     = count;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Storage is never cleared; stale words stay hidden behind the occupancy mask below.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc_i;
      instr_mem[wr_ptr] <= in_instr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]    : 32'h0;
  assign out_instr_o = out_valid_o ? instr_mem[rd_ptr] : NOP_INSTR;

endmodule
